// File: rtl/mha_arith_pkg.sv
// Shared arithmetic mode encodings and pipeline depth derivation for the
// segmented pipelined adder.
package mha_arith_pkg;

  typedef enum logic {
    ARITH_UNSIGNED = 1'b0,
    ARITH_SIGNED   = 1'b1
  } sign_mode_e;

  typedef enum logic {
    ARITH_ADD = 1'b0,
    ARITH_SUB = 1'b1
  } op_mode_e;

  // One pipeline stage per segment; width is assumed to be a whole multiple.
  function automatic int calc_nseg(input int w, input int seg);
    return w / seg;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One SEG-bit slice of the ripple-across-stages adder: plain combinational
// add with carry in and carry out.
module adder_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] op_a,
  input  logic [SEG-1:0] op_b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out
);

  logic [SEG:0] total;

  assign total     = {1'b0, op_a} + {1'b0, op_b} + {{SEG{1'b0}}, carry_in};
  assign sum       = total[SEG-1:0];
  assign carry_out = total[SEG];

endmodule

// File: rtl/pipe_adder.sv
// Segmented pipelined add/sub with valid/ready flow control, one segment per stage.
// Optional output saturation is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder
  import mha_arith_pkg::*;
#(
  parameter int W   = 16,
  parameter int SEG = 4
) (
  input  logic         I_CLK,
  input  logic         I_RST_N,
  input  logic         I_VALID,
  output logic         O_READY,
  input  logic [W-1:0] I_IN1,
  input  logic [W-1:0] I_IN2,
  input  logic         I_SIGNED,
  input  logic         I_SUB,
  output logic         O_VALID,
  input  logic         I_READY,
  output logic [W:0]   O_SUM,
  output logic         O_OVF
);

  localparam int NSEG = calc_nseg(W, SEG);
  localparam int L    = NSEG - 1;

  // stage registers; the last stage's state lives in sum_q/ovf_q/v_q[L]
  logic [W-1:0]    a_q   [NSEG];
  logic [W-1:0]    b_q   [NSEG];
  logic [W-1:0]    s_q   [NSEG];
  logic            c_q   [NSEG];
  logic            sg_q  [NSEG];
  logic            sub_q [NSEG];
  logic [NSEG-1:0] v_q;
  logic [W:0]      sum_q;
  logic            ovf_q;

  logic [W-1:0]    a_in   [NSEG];
  logic [W-1:0]    b_in   [NSEG];
  logic [W-1:0]    s_in   [NSEG];
  logic [W-1:0]    s_nxt  [NSEG];
  logic            c_in   [NSEG];
  logic            sg_in  [NSEG];
  logic            sub_in [NSEG];
  logic [NSEG-1:0] v_in;

  logic [SEG-1:0]  seg_a   [NSEG];
  logic [SEG-1:0]  seg_b   [NSEG];
  logic [SEG-1:0]  seg_sum [NSEG];
  logic            seg_co  [NSEG];

  logic            advance;
  logic            ext_a;
  logic            ext_b;
  logic [W:0]      full;
  logic [W:0]      res;
  logic            ovf_nxt;

  assign advance = I_READY || !v_q[L];
  assign O_READY = advance;
  assign O_VALID = v_q[L];
  assign O_SUM   = sum_q;
  assign O_OVF   = ovf_q;

  // subtraction is folded in at entry: operand 2 inverted, carry-in = I_SUB
  always_comb begin : stage_inputs
    a_in[0]   = I_IN1;
    b_in[0]   = (I_SUB == ARITH_SUB) ? ~I_IN2 : I_IN2;
    s_in[0]   = '0;
    c_in[0]   = I_SUB;
    sg_in[0]  = I_SIGNED;
    sub_in[0] = I_SUB;
    v_in[0]   = I_VALID;
    for (int k = 1; k < NSEG; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      s_in[k]   = s_q[k-1];
      c_in[k]   = c_q[k-1];
      sg_in[k]  = sg_q[k-1];
      sub_in[k] = sub_q[k-1];
      v_in[k]   = v_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg_a[k] = a_in[k][k*SEG +: SEG];
      seg_b[k] = b_in[k][k*SEG +: SEG];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    adder_seg #(.SEG(SEG)) u_seg (
      .op_a      (seg_a[k]),
      .op_b      (seg_b[k]),
      .carry_in  (c_in[k]),
      .sum       (seg_sum[k]),
      .carry_out (seg_co[k])
    );
  end

  always_comb begin : stage_sums
    for (int k = 0; k < NSEG; k++) begin
      s_nxt[k] = s_in[k] | (W'(seg_sum[k]) << (k*SEG));
    end
  end

  // Bit W: extension bits of both (possibly inverted) operands plus final carry.
  // An inverted zero-extended operand has a 1 in its extension bit.
  always_comb begin : final_stage
    ext_a   = (sg_in[L] == ARITH_SIGNED) ? a_in[L][W-1] : 1'b0;
    ext_b   = (sg_in[L] == ARITH_SIGNED) ? b_in[L][W-1] : sub_in[L];
    full    = {ext_a ^ ext_b ^ seg_co[L], s_nxt[L]};
    res     = full;
    ovf_nxt = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    if (sg_in[L] == ARITH_SIGNED) begin
      if (full[W] != full[W-1]) begin
        ovf_nxt = 1'b1;
        res     = full[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
      end
    end else if (full[W]) begin
      ovf_nxt = 1'b1;
      res     = (sub_in[L] == ARITH_SUB) ? '0 : {1'b0, {W{1'b1}}};
    end
`endif
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      v_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sg_q[k]  <= 1'b0;
        sub_q[k] <= 1'b0;
      end
    end else if (advance) begin
      v_q   <= v_in;
      sum_q <= res;
      ovf_q <= ovf_nxt;
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= s_nxt[k];
        c_q[k]   <= seg_co[k];
        sg_q[k]  <= sg_in[k];
        sub_q[k] <= sub_in[k];
      end
    end
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter W, default 16: operand width in bits.
REQ-002 SHALL have parameter SEG, default 4: segment width in bits, one pipeline stage per segment. W SHALL be an integer multiple of SEG; NSEG = W/SEG.
REQ-003 SHALL have port I_CLK  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port I_RST_N  input  1: synchronous, active-low reset.
REQ-005 SHALL have port I_VALID  input  1: operand set present.
REQ-006 SHALL have port O_READY  output  1: block accepts an operand set this cycle.
REQ-007 SHALL have ports I_IN1 and I_IN2  input  W: operands.
REQ-008 SHALL have port I_SIGNED  input  1: 1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port I_SUB  input  1: 1 = I_IN1 - I_IN2, 0 = I_IN1 + I_IN2.
REQ-010 SHALL have port O_VALID  output  1: O_SUM and O_OVF are valid.
REQ-011 SHALL have port I_READY  input  1: downstream accepts the result.
REQ-012 SHALL have port O_SUM  output  W+1: result.
REQ-013 SHALL have port O_OVF  output  1: saturation occurred (see REQ-026).

Function
REQ-014 Accept occurs when I_VALID && O_READY; transfer out occurs when O_VALID && I_READY.
REQ-015 O_READY SHALL equal I_READY || !O_VALID; the whole pipeline SHALL stall as one unit when O_VALID && !I_READY.
REQ-016 Arithmetic: ext(x) is the W+1-bit sign extension when I_SIGNED=1 and zero extension otherwise. The full-precision result SHALL be ext(I_IN1) ± ext(I_IN2) mod 2^(W+1).
REQ-017 Subtraction SHALL be implemented as I_IN1 + ~I_IN2 with carry-in 1; segment 0 carry-in SHALL equal I_SUB.
REQ-018 Stage k (0..NSEG-1) SHALL add segment k of both operands plus the registered carry from stage k-1. Upper segments and the I_SIGNED/I_SUB flags SHALL be delayed alongside their segments.
REQ-019 Latency SHALL be NSEG cycles from accept to O_VALID, with no stall in between. NSEG=1 SHALL give a single registered stage.
REQ-020 Throughput SHALL be one result per cycle with no bubbles while I_VALID=1 and I_READY=1.
REQ-021 Each stage SHALL carry a valid bit. Bubbles SHALL propagate and SHALL NOT be collapsed; results SHALL leave in accept order.
REQ-022 While stalled, O_SUM, O_OVF and O_VALID SHALL hold constant, and no accepted operand set SHALL be lost or duplicated.
REQ-023 Flags SHALL be sampled per operand set at accept; changing I_SIGNED or I_SUB between consecutive sets SHALL NOT affect sets already in flight.

Reset
REQ-024 When I_RST_N=0 at a clock edge, all stage valid bits, O_VALID, O_SUM and O_OVF SHALL be 0 after that edge. O_READY SHALL then be 1.
REQ-025 Reset mid-operation SHALL discard all in-flight operand sets; no result from them SHALL appear after reset release.

Configuration
REQ-026 With macro PIPE_ADDER_SAT_EN defined, the final stage SHALL clamp the result before the output register:
- unsigned add > 2^W-1 -> 2^W-1
- unsigned sub < 0 -> 0
- signed result outside [-2^(W-1), 2^(W-1)-1] -> nearest bound
O_SUM[W] SHALL then be the sign extension (signed) or 0 (unsigned), and O_OVF SHALL be 1 exactly when clamping occurred.
REQ-027 Without PIPE_ADDER_SAT_EN, O_SUM SHALL be the full-precision result and O_OVF SHALL be constant 0. Ports and latency SHALL be identical in both builds.

Structure
REQ-028 Package mha_arith_pkg SHALL hold the mode encodings (signed/unsigned, add/sub) and the NSEG derivation function.
REQ-029 One sub-module, adder_seg, SHALL implement a SEG-bit combinational add with carry-in/carry-out; pipe_adder SHALL instantiate NSEG of them via generate.

Verification (W=16, SEG=4, latency 4)
REQ-030 Unsigned add 0xFFFF + 0x0001 -> O_SUM=0x10000 four cycles after accept, O_OVF=0; with SAT_EN -> 0x0FFFF, O_OVF=1.
REQ-031 Signed add 0x7FFF + 0x0001 -> O_SUM=0x08000; with SAT_EN -> 0x07FFF, O_OVF=1. Signed 0x8000 - 0x0001 with SAT_EN -> 0x18000, O_OVF=1.
REQ-032 Unsigned sub 0x0000 - 0x0001 -> O_SUM=0x1FFFF; with SAT_EN -> 0x00000, O_OVF=1.
REQ-033 Eight back-to-back sets with alternating I_SUB, and I_READY=0 on cycles 6-8 -> O_SUM and O_VALID held during the stall, all 8 results delivered in order, none lost or duplicated.
REQ-034 Reset asserted two cycles after accepting three sets -> O_VALID=0 after the reset edge, and no result appears after release until new accepts.
